// File: rtl/posit_mult_core.sv
// posit_mult_core: iterative shift-add posit mantissa multiply, normalise and scale sum (optional clamp via POSIT_MULT_SATURATE_EN)
module posit_mult_core #(
    parameter int N  = 8,
    parameter int ES = 4,
    parameter int RS = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 S1,
    input  logic                 S2,
    input  logic [RS:0]          K1,
    input  logic [RS:0]          K2,
    input  logic [ES-1:0]        E1,
    input  logic [ES-1:0]        E2,
    input  logic [N-1:0]         M1,
    input  logic [N-1:0]         M2,
    input  logic                 Inf1,
    input  logic                 Inf2,
    input  logic                 Zero1,
    input  logic                 Zero2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N-1:0]       Mult_Mant_N,
    output logic [RS+ES+1:0]     Total_EO,
    output logic [ES-1:0]        E_O,
    output logic [RS:0]          R_O,
    output logic                 inf,
    output logic                 zero,
    output logic                 Operation
`ifdef POSIT_MULT_SATURATE_EN
    ,
    output logic                 sat_flag
`endif
);
    localparam int TW = RS + ES + 2;
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
    state_t state, state_n;
    logic [RS:0] k1_q, k2_q;
    logic [ES-1:0] e1_q, e2_q;
    logic [N-1:0] m1_q, m2_q;
    logic [2*N-1:0] acc;
    logic [CW-1:0] cnt;
    logic special, ovf, sat;
    logic signed [RS+ES:0] ke1, ke2;
    logic signed [TW-1:0] raw, tot;
    logic [RS:0] rg, r_o_n;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign special   = Inf1 | Inf2 | Zero1 | Zero2;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? (special ? DONE : MUL) : IDLE;
            MUL:     state_n = cnt == CW'(N-1) ? NORM : MUL;
            NORM:    state_n = DONE;
            default: state_n = out_ready ? IDLE : DONE;
        endcase
    end
    // the scale is the signed concatenation {k, e}; a mantissa overflow adds one
    always_comb begin
        ovf = acc[2*N-1];
        ke1 = {k1_q, e1_q};
        ke2 = {k2_q, e2_q};
        raw = TW'(ke1) + TW'(ke2) + TW'(ovf);
`ifdef POSIT_MULT_SATURATE_EN
        sat = (raw > TW'((N-1)*(2**ES)-1)) || (raw < TW'(-(N-1)*(2**ES)));
        tot = raw > TW'((N-1)*(2**ES)-1) ? TW'((N-1)*(2**ES)-1) :
              raw < TW'(-(N-1)*(2**ES))  ? TW'(-(N-1)*(2**ES))  : raw;
`else
        sat = 1'b0;
        tot = raw;
`endif
        rg    = tot[ES+RS:ES];
        r_o_n = tot[TW-1] ? -rg : rg + (RS+1)'(1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            k1_q        <= '0;
            k2_q        <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            m1_q        <= '0;
            m2_q        <= '0;
            acc         <= '0;
            cnt         <= '0;
            Mult_Mant_N <= '0;
            Total_EO    <= '0;
            E_O         <= '0;
            R_O         <= '0;
            inf         <= 1'b0;
            zero        <= 1'b0;
            Operation   <= 1'b0;
`ifdef POSIT_MULT_SATURATE_EN
            sat_flag    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                k1_q        <= K1;
                k2_q        <= K2;
                e1_q        <= E1;
                e2_q        <= E2;
                m1_q        <= M1;
                m2_q        <= M2;
                acc         <= '0;
                cnt         <= '0;
                Mult_Mant_N <= '0;
                Total_EO    <= '0;
                E_O         <= '0;
                R_O         <= '0;
                Operation   <= S1 ^ S2;
                inf         <= Inf1 | Inf2;
                zero        <= !(Inf1 | Inf2) && (Zero1 | Zero2);
`ifdef POSIT_MULT_SATURATE_EN
                sat_flag    <= 1'b0;
`endif
            end
            if (state == MUL) begin
                acc <= acc + (m2_q[cnt] ? (2*N)'(m1_q) << cnt : '0);
                cnt <= cnt + CW'(1);
            end
            if (state == NORM) begin
                Mult_Mant_N <= ovf ? acc : acc << 1;
                Total_EO    <= tot;
                E_O         <= tot[ES-1:0];
                R_O         <= r_o_n;
`ifdef POSIT_MULT_SATURATE_EN
                sat_flag    <= sat;
`endif
            end
        end
    end
endmodule
